sap1_controller: RTL and testbench
==================================

Name: sap1_controller

Overview:
- Instruction register plus controller-sequencer for the SAP-1 datapath.
- Downstream of the program RAM: it captures the instruction byte that RAM drives onto the W bus during the fetch memory state.
- Runs a 6-state one-hot ring counter (T1..T6) and decodes the ring state and opcode into the 12-bit control word that drives PC, MAR, RAM, IR, A, ALU, B and OUT.
- Owns the halt condition.

Parameters:
- HALT_ON_UNDEF, default 0: 1 makes an undefined opcode halt at T4; 0 makes it execute T4..T6 as no-ops.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- W  in  8  bus value; captured into IR when the IR load strobe nLi is active.
- con  out  12  control word, bit order [11:0] = {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}. Bits prefixed n are active-low.
- ir_addr  out  4  IR[3:0], the operand address the IR puts on the bus when nEi=0. Bus muxing is done outside this block.
- opcode  out  4  IR[7:4].
- t  out  6  one-hot ring state; bit0 = T1.
- hlt  out  1  high once halted.

Behaviour:
- Reset: at a clk edge with clr=1, ring goes to T1, IR=8'h00 and hlt=0.
  - While clr=1, con is forced to idle 12'h3E3.
  - With clr=1 held, the first cycle after the edge still shows idle con. T1 decode appears once clr=0.
  - clr mid-instruction aborts immediately; no partial state is kept.
- Ring: advances T1→T2→…→T6→T1 every clk while clr=0 and hlt=0. It holds its value while hlt=1.
- con is Moore: a purely combinational decode of registered ring, IR and hlt. Zero-cycle latency from state to con.
- Fetch (all opcodes):
  - T1 = 0x5E3 (Ep, nLm).
  - T2 = 0xBE3 (Cp).
  - T3 = 0x263 (nCE, nLi).
  - IR <= W at the clk edge that ends T3. T4 decode therefore uses the new opcode.
- Execute, T4/T5/T6 by opcode:
  - LDA 0000: 0x1A3 / 0x2C3 / 0x3E3.
  - ADD 0001: 0x1A3 / 0x2E1 / 0x3C7.
  - SUB 0010: 0x1A3 / 0x2E1 / 0x3CF.
  - OUT 1110: 0x3F2 / 0x3E3 / 0x3E3.
  - HLT 1111: con idle in T4. hlt is set at the edge ending T4; the ring freezes at T4 afterwards.
  - Any other opcode: T4..T6 idle (0x3E3). If HALT_ON_UNDEF=1, it instead behaves as HLT.
- Halted: con = 0x3E3, t holds T4, IR is frozen and W is ignored. Only clr exits the halted state.
- IR is written only in T3 and never in any other state.
- con encoding invariants:
  - At most one bus driver is active per cycle (Ep, nCE=0, nEi=0, Ea, Eu).
  - No active-low strobe is ever X. Every con bit is fully defined in every reachable state.
- t is always exactly one-hot. If an illegal ring value is reached (e.g. an SEU), the next edge forces T1.

Decomposition:
- Package sap1_pkg holds:
  - the opcode constants OP_LDA/OP_ADD/OP_SUB/OP_OUT/OP_HLT;
  - the con bit-index localparams;
  - the named control-word constants CW_IDLE, CW_T1, CW_T2, CW_T3, CW_MEMADDR, CW_LDA5, CW_ALU5, CW_ADD6, CW_SUB6, CW_OUT4.
- One sub-module, sap1_ring_counter: 6-bit one-hot ring with clr, a hold input and illegal-state recovery.
- IR register, halt flag and decode stay in sap1_controller.

Test Plan:
- Reset: hold clr=1 for 2 clks, then release → t=6'b000001, con=0x5E3, hlt=0, IR=0. After 2 edges t=T3 and con=0x263.
- LDA fetch/execute: W=8'h0A during T3 → opcode=0, ir_addr=4'hA. con sequence across T4,T5,T6 is 0x1A3, 0x2C3, 0x3E3, then T1=0x5E3.
- ADD then SUB: W=8'h1B, then on the next instruction W=8'h2C → T6 con=0x3C7 for ADD and 0x3CF for SUB. T5=0x2E1 for both.
- OUT then HLT: W=8'hE0 → T4 con=0x3F2. Next instruction W=8'hF0 → hlt=1 after the T4 edge; t stays 6'b001000 and con=0x3E3 for 20 clks while W toggles.
- Undefined opcode 8'h50: with HALT_ON_UNDEF=0, T4..T6 = 0x3E3 and the ring continues to T1. With HALT_ON_UNDEF=1, hlt=1 after T4.
- clr asserted in T5 of an ADD → the next edge gives t=T1 and IR=0; con=0x3E3 while clr is held.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared opcode, control-word and ring-state definitions for the SAP-1 controller.
package sap1_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word bit positions, MSB first: {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
  localparam int CON_CP  = 11;
  localparam int CON_EP  = 10;
  localparam int CON_NLM = 9;
  localparam int CON_NCE = 8;
  localparam int CON_NLI = 7;
  localparam int CON_NEI = 6;
  localparam int CON_NLA = 5;
  localparam int CON_EA  = 4;
  localparam int CON_SU  = 3;
  localparam int CON_EU  = 2;
  localparam int CON_NLB = 1;
  localparam int CON_NLO = 0;

  // Named control words; idle has every active-low strobe high and every driver off.
  localparam logic [11:0] CW_IDLE    = 12'h3E3;
  localparam logic [11:0] CW_T1      = 12'h5E3;  // Ep, nLm: PC -> MAR
  localparam logic [11:0] CW_T2      = 12'hBE3;  // Cp: PC increment
  localparam logic [11:0] CW_T3      = 12'h263;  // nCE, nLi: RAM -> IR
  localparam logic [11:0] CW_MEMADDR = 12'h1A3;  // nEi, nLm: IR addr -> MAR
  localparam logic [11:0] CW_LDA5    = 12'h2C3;  // nCE, nLa: RAM -> A
  localparam logic [11:0] CW_ALU5    = 12'h2E1;  // nCE, nLb: RAM -> B
  localparam logic [11:0] CW_ADD6    = 12'h3C7;  // Eu, nLa: A+B -> A
  localparam logic [11:0] CW_SUB6    = 12'h3CF;  // Su, Eu, nLa: A-B -> A
  localparam logic [11:0] CW_OUT4    = 12'h3F2;  // Ea, nLo: A -> OUT

  // One-hot ring states, bit0 = T1.
  localparam logic [5:0] RING_T1 = 6'b000001;
  localparam logic [5:0] RING_T2 = 6'b000010;
  localparam logic [5:0] RING_T3 = 6'b000100;
  localparam logic [5:0] RING_T4 = 6'b001000;
  localparam logic [5:0] RING_T5 = 6'b010000;
  localparam logic [5:0] RING_T6 = 6'b100000;

  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'b0) && ((v & (v - 6'd1)) == 6'b0);
  endfunction

  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter with hold and recovery from non-one-hot values.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       hold,
  output logic [5:0] t
);

  // Rotate each edge unless held; any illegal pattern snaps back to T1 even while held.
  always_ff @(posedge clk) begin
    if (clr) begin
      t <= RING_T1;
    end else if (!is_onehot6(t)) begin
      t <= RING_T1;
    end else if (!hold) begin
      t <= {t[4:0], t[5]};
    end
  end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 instruction register, halt flag and control-word decoder.
//
// state | meaning
// T1    | PC -> MAR
// T2    | PC increment
// T3    | RAM -> IR (IR loads at the edge ending T3)
// T4    | execute step 1 (HLT/undefined-halt sets hlt here)
// T5    | execute step 2
// T6    | execute step 3
module sap1_controller
  import sap1_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  W,
  output logic [11:0] con,
  output logic [3:0]  ir_addr,
  output logic [3:0]  opcode,
  output logic [5:0]  t,
  output logic        hlt
);

  logic [7:0] ir;
  logic       halt_op;
  logic       halt_now;
  logic       ld_ir;

  assign opcode  = ir[7:4];
  assign ir_addr = ir[3:0];

  assign halt_op  = (opcode == OP_HLT) || (HALT_ON_UNDEF && !is_defined_op(opcode));
  // Freeze the ring on the same edge that sets hlt so it stays parked at T4.
  assign halt_now = (t == RING_T4) && halt_op && !hlt;
  assign ld_ir    = (t == RING_T3) && !hlt;

  sap1_ring_counter u_ring (
    .clk  (clk),
    .clr  (clr),
    .hold (hlt | halt_now),
    .t    (t)
  );

  // Instruction register: captured only at the end of T3.
  always_ff @(posedge clk) begin
    if (clr) begin
      ir <= 8'h00;
    end else if (ld_ir) begin
      ir <= W;
    end
  end

  // Halt flag: sticky until clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      hlt <= 1'b0;
    end else if (halt_now) begin
      hlt <= 1'b1;
    end
  end

  // Moore decode of ring, opcode and hlt; clr forces idle immediately.
  always_comb begin
    con = CW_IDLE;
    if (!clr && !hlt) begin
      case (t)
        RING_T1: con = CW_T1;
        RING_T2: con = CW_T2;
        RING_T3: con = CW_T3;
        RING_T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: con = CW_MEMADDR;
            OP_OUT:                 con = CW_OUT4;
            default:                con = CW_IDLE;
          endcase
        end
        RING_T5: begin
          case (opcode)
            OP_LDA:         con = CW_LDA5;
            OP_ADD, OP_SUB: con = CW_ALU5;
            default:        con = CW_IDLE;
          endcase
        end
        RING_T6: begin
          case (opcode)
            OP_ADD:  con = CW_ADD6;
            OP_SUB:  con = CW_SUB6;
            default: con = CW_IDLE;
          endcase
        end
        default: con = CW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Directed self-checking bench for sap1_controller (both HALT_ON_UNDEF settings).
module tb_sap1_controller;

  logic        clk;
  logic        clr, clr1;
  logic [7:0]  w, w1;
  logic [11:0] con, con1;
  logic [3:0]  ir_addr, ir_addr1, opcode, opcode1;
  logic [5:0]  t, t1;
  logic        hlt, hlt1;

  int checks = 0;
  int errors = 0;

  sap1_controller #(.HALT_ON_UNDEF(1'b0)) dut (
    .clk(clk), .clr(clr), .W(w), .con(con),
    .ir_addr(ir_addr), .opcode(opcode), .t(t), .hlt(hlt)
  );

  sap1_controller #(.HALT_ON_UNDEF(1'b1)) dut_undef (
    .clk(clk), .clr(clr1), .W(w1), .con(con1),
    .ir_addr(ir_addr1), .opcode(opcode1), .t(t1), .hlt(hlt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks T1..T3 from the current T1 and presents instr during T3; ends in T4.
  task automatic fetch(input logic [7:0] instr);
    chk("t1_ring", {6'h0, t}, 12'h001);
    chk("t1_con", con, 12'h5E3);
    step();
    chk("t2_ring", {6'h0, t}, 12'h002);
    chk("t2_con", con, 12'hBE3);
    step();
    chk("t3_ring", {6'h0, t}, 12'h004);
    chk("t3_con", con, 12'h263);
    w = instr;
    step();
    chk("ir_opcode", {8'h0, opcode}, {8'h0, instr[7:4]});
    chk("ir_addr", {8'h0, ir_addr}, {8'h0, instr[3:0]});
  endtask

  // Checks T4..T6 control words from T4; ends in the next T1.
  task automatic exec(input string name, input logic [11:0] c4, input logic [11:0] c5,
                      input logic [11:0] c6);
    chk({name, "_t4_ring"}, {6'h0, t}, 12'h008);
    chk({name, "_t4_con"}, con, c4);
    step();
    chk({name, "_t5_ring"}, {6'h0, t}, 12'h010);
    chk({name, "_t5_con"}, con, c5);
    step();
    chk({name, "_t6_ring"}, {6'h0, t}, 12'h020);
    chk({name, "_t6_con"}, con, c6);
    step();
    chk({name, "_next_t1"}, {6'h0, t}, 12'h001);
    chk({name, "_hlt"}, {11'h0, hlt}, 12'h000);
  endtask

  initial begin
    clr = 1'b1; clr1 = 1'b1;
    w = 8'hFF;  w1 = 8'h00;

    // Reset held for two edges.
    step();
    step();
    chk("rst_ring", {6'h0, t}, 12'h001);
    chk("rst_con_idle", con, 12'h3E3);
    chk("rst_hlt", {11'h0, hlt}, 12'h000);
    chk("rst_ir", {4'h0, opcode, ir_addr}, 12'h000);
    clr = 1'b0;
    #1;
    chk("rel_con_t1", con, 12'h5E3);

    // LDA, ADD, SUB, undefined (continues).
    fetch(8'h0A);
    exec("lda", 12'h1A3, 12'h2C3, 12'h3E3);
    chk("lda_t1_con", con, 12'h5E3);
    fetch(8'h1B);
    exec("add", 12'h1A3, 12'h2E1, 12'h3C7);
    fetch(8'h2C);
    exec("sub", 12'h1A3, 12'h2E1, 12'h3CF);
    fetch(8'h50);
    exec("undef", 12'h3E3, 12'h3E3, 12'h3E3);

    // clr during T5 of an ADD aborts the instruction.
    fetch(8'h1B);
    step();
    chk("abort_t5_ring", {6'h0, t}, 12'h010);
    clr = 1'b1;
    #1;
    chk("abort_con_idle", con, 12'h3E3);
    step();
    chk("abort_ring_t1", {6'h0, t}, 12'h001);
    chk("abort_ir_zero", {4'h0, opcode, ir_addr}, 12'h000);
    chk("abort_con_held", con, 12'h3E3);
    clr = 1'b0;
    #1;

    // OUT then HLT.
    fetch(8'hE0);
    exec("out", 12'h3F2, 12'h3E3, 12'h3E3);
    fetch(8'hF0);
    chk("hlt_t4_con", con, 12'h3E3);
    chk("hlt_t4_flag", {11'h0, hlt}, 12'h000);
    step();
    chk("hlt_set", {11'h0, hlt}, 12'h001);
    chk("hlt_ring_t4", {6'h0, t}, 12'h008);
    for (int i = 0; i < 20; i++) begin
      w = (i % 2 == 0) ? 8'h0A : 8'h1B;
      step();
      chk("halted_ring", {6'h0, t}, 12'h008);
      chk("halted_con", con, 12'h3E3);
      chk("halted_ir", {4'h0, opcode, ir_addr}, 12'h0F0);
      chk("halted_flag", {11'h0, hlt}, 12'h001);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    chk("unhalt_ring", {6'h0, t}, 12'h001);
    chk("unhalt_flag", {11'h0, hlt}, 12'h000);
    chk("unhalt_con", con, 12'h5E3);

    // HALT_ON_UNDEF=1: opcode 5 halts at T4.
    clr1 = 1'b0;
    #1;
    chk("u_t1_con", con1, 12'h5E3);
    step();
    step();
    chk("u_t3_ring", {6'h0, t1}, 12'h004);
    w1 = 8'h50;
    step();
    chk("u_t4_con", con1, 12'h3E3);
    chk("u_t4_flag", {11'h0, hlt1}, 12'h000);
    step();
    chk("u_hlt_set", {11'h0, hlt1}, 12'h001);
    chk("u_ring_t4", {6'h0, t1}, 12'h008);
    step();
    chk("u_ring_hold", {6'h0, t1}, 12'h008);
    chk("u_con_idle", con1, 12'h3E3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
